// File: rtl/cpu_pkg.sv
// Shared CPU definitions: transfer FSM states, register indices, data width.
package cpu_pkg;

  localparam int W_DEF = 32;

  // Register-bank index map
  localparam int REG_PC   = 0;
  localparam int REG_IR   = 1;
  localparam int REG_A    = 2;
  localparam int REG_B    = 3;
  localparam int REG_HI   = 4;
  localparam int REG_LO   = 5;
  localparam int REG_TMP0 = 6;
  localparam int REG_TMP1 = 7;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } xfer_state_t;

  // True when a register index names a register that exists in the bank
  function automatic logic idx_ok(input int unsigned idx, input int unsigned n);
    return idx < n;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Index to one-hot strobe decoder; all outputs low when disabled.
module onehot_dec #(
  parameter int N  = 8,
  parameter int IW = $clog2(N)
) (
  input  logic [IW-1:0] idx,
  input  logic          en,
  output logic [N-1:0]  oh
);

  // Out-of-range indices simply decode to no strobe
  always_comb begin
    oh = '0;
    for (int i = 0; i < N; i++)
      if (en && (idx == IW'(i))) oh[i] = 1'b1;
  end

endmodule

// File: rtl/reg_xfer_ctrl.sv
// Register transfer sequencer: read strobe, capture, then write strobe.
module reg_xfer_ctrl
  import cpu_pkg::*;
#(
  parameter int NREG = 8,
  parameter int W    = W_DEF,
  parameter int IW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_imm_op,
  input  logic [IW-1:0]   req_src,
  input  logic [IW-1:0]   req_dst,
  input  logic [W-1:0]    req_imm,
  input  logic [W-1:0]    bus,
  output logic [NREG-1:0] rd_en,
  output logic [NREG-1:0] wr_en,
  output logic [W-1:0]    wdata,
  output logic            done,
  output logic            err
);

  xfer_state_t   state_q, state_d;
  logic [IW-1:0] src_q, src_d;
  logic [IW-1:0] dst_q, dst_d;
  logic [W-1:0]  tmp_q, tmp_d;

  logic          src_ok, dst_ok;

  assign src_ok = idx_ok(32'(req_src), NREG);
  assign dst_ok = idx_ok(32'(req_dst), NREG);

  // Next-state and datapath: latch request in IDLE, capture bus at end of READ
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    tmp_d   = tmp_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          src_d = req_src;
          dst_d = req_dst;
          if (!dst_ok || (!req_imm_op && !src_ok)) begin
            state_d = ERR;
          end else if (req_imm_op) begin
            tmp_d   = req_imm;
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        tmp_d   = bus;
        state_d = WRITE;
      end
      WRITE:   state_d = DONE;
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any transfer and clears the capture register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      tmp_q   <= '0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      tmp_q   <= tmp_d;
    end
  end

  // Outputs come only from registered state, never straight from req_*
  assign req_ready = (state_q == IDLE);
  assign done      = (state_q == DONE) || (state_q == ERR);
  assign err       = (state_q == ERR);
  assign wdata     = tmp_q;

  onehot_dec #(.N(NREG), .IW(IW)) u_rd_dec (
    .idx (src_q),
    .en  (state_q == READ),
    .oh  (rd_en)
  );

  onehot_dec #(.N(NREG), .IW(IW)) u_wr_dec (
    .idx (dst_q),
    .en  (state_q == WRITE),
    .oh  (wr_en)
  );

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Self-checking bench: random transfers against a register-file reference model.
module tb_reg_xfer_ctrl;

  localparam int NREG = 6;
  localparam int W    = 32;
  localparam int IW   = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            req_valid = 1'b0;
  logic            req_ready;
  logic            req_imm_op = 1'b0;
  logic [IW-1:0]   req_src = '0;
  logic [IW-1:0]   req_dst = '0;
  logic [W-1:0]    req_imm = '0;
  logic [W-1:0]    bus;
  logic [NREG-1:0] rd_en, wr_en;
  logic [W-1:0]    wdata;
  logic            done, err;

  int chk_total = 0;
  int chk_pass  = 0;
  int overlap_cnt = 0;

  logic [W-1:0] bank    [NREG];
  logic [W-1:0] ref_reg [NREG];

  reg_xfer_ctrl #(.NREG(NREG), .W(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_imm_op(req_imm_op), .req_src(req_src), .req_dst(req_dst),
    .req_imm(req_imm), .bus(bus), .rd_en(rd_en), .wr_en(wr_en),
    .wdata(wdata), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Register bank model: drives the bus when selected, writes on strobe
  always_comb begin
    bus = 'z;
    for (int i = 0; i < NREG; i++)
      if (rd_en[i]) bus = bank[i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++)
      if (wr_en[i]) bank[i] <= wdata;
  end

  // Strobe hygiene monitor
  always @(negedge clk) begin
    if ((rd_en != '0 && wr_en != '0) || $countones(rd_en) > 1 || $countones(wr_en) > 1)
      overlap_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NREG-1:0] oh(input int idx);
    logic [NREG-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // One full transfer with per-cycle checks; updates the reference model
  task automatic run_xfer(input bit imm, input int src, input int dst, input logic [W-1:0] iv);
    bit is_err;
    logic [W-1:0] val;
    int n;
    n = 0;
    while (!req_ready && n < 8) begin tick(); n++; end
    chk_total++;
    if (req_ready !== 1'b1) $display("FAIL ready_wait: req_ready=%b want 1", req_ready);
    else chk_pass++;
    is_err = (dst >= NREG) || (!imm && src >= NREG);
    val = imm ? iv : (is_err ? '0 : ref_reg[src]);
    req_valid = 1'b1; req_imm_op = imm; req_src = IW'(src); req_dst = IW'(dst); req_imm = iv;
    tick();
    req_valid = 1'b0;
    if (is_err) begin
      chk_total++;
      if ({done, err, rd_en, wr_en, req_ready} !== {2'b11, {2*NREG{1'b0}}, 1'b0})
        $display("FAIL err_cycle: done=%b err=%b rd=%b wr=%b rdy=%b want 1 1 0 0 0",
                 done, err, rd_en, wr_en, req_ready);
      else chk_pass++;
    end else begin
      if (!imm) begin
        chk_total++;
        if ({rd_en, wr_en, done, req_ready} !== {oh(src), {NREG{1'b0}}, 2'b00})
          $display("FAIL read_cycle: rd=%b wr=%b done=%b rdy=%b want rd=%b", rd_en, wr_en, done, req_ready, oh(src));
        else chk_pass++;
        tick();
      end
      chk_total++;
      if ({wr_en, rd_en, done} !== {oh(dst), {NREG{1'b0}}, 1'b0})
        $display("FAIL write_strobe: wr=%b rd=%b done=%b want wr=%b", wr_en, rd_en, done, oh(dst));
      else chk_pass++;
      chk_total++;
      if (wdata !== val) $display("FAIL write_data: wdata=%h want %h", wdata, val);
      else chk_pass++;
      tick();
      chk_total++;
      if ({done, err, rd_en, wr_en} !== {2'b10, {2*NREG{1'b0}}})
        $display("FAIL done_cycle: done=%b err=%b rd=%b wr=%b want 1 0 0 0", done, err, rd_en, wr_en);
      else chk_pass++;
      ref_reg[dst] = val;
    end
    tick();
    chk_total++;
    if ({req_ready, done} !== 2'b10) $display("FAIL ready_after: rdy=%b done=%b want 1 0", req_ready, done);
    else chk_pass++;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    req_valid = 1'b1; req_imm_op = 1'b0; req_src = 3'd1; req_dst = 3'd2;
    for (int c = 0; c < 2; c++) begin
      tick();
      chk_total++;
      if ({rd_en, wr_en, done, err, req_ready} !== {{2*NREG{1'b0}}, 3'b001})
        $display("FAIL reset_hold: rd=%b wr=%b done=%b err=%b rdy=%b want 0 0 0 0 1",
                 rd_en, wr_en, done, err, req_ready);
      else chk_pass++;
    end
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    chk_total++;
    if ({rd_en, wr_en, done, req_ready, wdata} !== {{2*NREG{1'b0}}, 2'b01, {W{1'b0}}})
      $display("FAIL reset_release: rd=%b wr=%b done=%b rdy=%b wdata=%h want idle, wdata 0",
               rd_en, wr_en, done, req_ready, wdata);
    else chk_pass++;
  endtask

  task automatic test_move;
    bank[2] = 32'hDEAD_BEEF; ref_reg[2] = 32'hDEAD_BEEF;
    run_xfer(1'b0, 2, 5, 32'h0);
    run_xfer(1'b0, 4, 4, 32'h0);   // src == dst
  endtask

  task automatic test_imm;
    run_xfer(1'b1, 0, 0, 32'h0040_0000);
    run_xfer(1'b1, 7, 3, 32'h1234_5678); // bad src ignored for immediates
  endtask

  task automatic test_err;
    run_xfer(1'b0, 1, 7, 32'h0);
    run_xfer(1'b0, 6, 1, 32'h0);
    run_xfer(1'b1, 0, 6, 32'hFFFF_FFFF);
  endtask

  task automatic test_random;
    for (int t = 0; t < 40; t++)
      run_xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 7)), $urandom);
  endtask

  task automatic test_back_to_back;
    int n;
    logic [W-1:0] v1, v2;
    v1 = ref_reg[1];
    req_valid = 1'b1; req_imm_op = 1'b0; req_src = 3'd1; req_dst = 3'd3;
    tick();
    req_src = 3'd3; req_dst = 3'd4;    // second request queued behind the first
    n = 1;
    while (!req_ready && n < 10) begin
      chk_total++;
      if ((rd_en & wr_en) !== '0) $display("FAIL b2b_overlap: rd=%b wr=%b", rd_en, wr_en);
      else chk_pass++;
      tick(); n++;
    end
    chk_total++;
    if (n !== 4) $display("FAIL b2b_spacing: handshake gap=%0d want 4", n);
    else chk_pass++;
    ref_reg[3] = v1;
    v2 = ref_reg[3];
    tick();
    chk_total++;
    if (rd_en !== oh(3)) $display("FAIL b2b_read2: rd=%b want %b", rd_en, oh(3));
    else chk_pass++;
    req_valid = 1'b0;
    tick();
    chk_total++;
    if ({wr_en, wdata} !== {oh(4), v2}) $display("FAIL b2b_write2: wr=%b wdata=%h want %b %h", wr_en, wdata, oh(4), v2);
    else chk_pass++;
    ref_reg[4] = v2;
    tick();
    chk_total++;
    if ({done, err} !== 2'b10) $display("FAIL b2b_done2: done=%b err=%b want 1 0", done, err);
    else chk_pass++;
    tick();
  endtask

  task automatic test_abort;
    logic [W-1:0] v;
    v = ref_reg[0];
    req_valid = 1'b1; req_imm_op = 1'b0; req_src = 3'd0; req_dst = 3'd2;
    tick();
    req_valid = 1'b0;
    tick();
    chk_total++;
    if (wr_en !== oh(2)) $display("FAIL abort_in_write: wr=%b want %b", wr_en, oh(2));
    else chk_pass++;
    ref_reg[2] = v;                    // strobe was high at the reset edge
    rst = 1'b0;
    tick();
    chk_total++;
    if ({rd_en, wr_en, done, wdata} !== {{2*NREG{1'b0}}, 1'b0, {W{1'b0}}})
      $display("FAIL abort_cycle: rd=%b wr=%b done=%b wdata=%h want all 0", rd_en, wr_en, done, wdata);
    else chk_pass++;
    rst = 1'b1;
    tick();
    chk_total++;
    if ({done, req_ready} !== 2'b01) $display("FAIL abort_after: done=%b rdy=%b want 0 1", done, req_ready);
    else chk_pass++;
    run_xfer(1'b1, 0, 1, 32'hCAFE_F00D);
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin
      bank[i] = $urandom; ref_reg[i] = bank[i];
    end
    #2;
    test_reset();
    test_move();
    test_imm();
    test_err();
    test_back_to_back();
    test_random();
    test_abort();
    for (int i = 0; i < NREG; i++) begin
      chk_total++;
      if (bank[i] !== ref_reg[i]) $display("FAIL bank_final[%0d]: got %h want %h", i, bank[i], ref_reg[i]);
      else chk_pass++;
    end
    chk_total++;
    if (overlap_cnt !== 0) $display("FAIL strobe_hygiene: violations=%0d want 0", overlap_cnt);
    else chk_pass++;
    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
